// File: rtl/ntt_perm_sequencer.sv
// ntt_perm_sequencer: carries one NTT vector through a chain of
// permute + core passes, owning the vector buffer between steps.
//
// Ports:
//   clk, rstn         clock, synchronous active-low reset
//   in_valid/ready    input vector handshake; in_data, cfg_seq, cfg_steps
//                     are captured when a vector is accepted
//   perm_select/in/out  external merged-permutation network
//   core_start/done   pulse/response handshake with the NTT core;
//                     core_data out, core_result in
//   out_valid/ready   result vector handshake; out_data
//   busy, step_idx    status; timeout_err is sticky per vector
module ntt_perm_sequencer #(
  parameter int SIZE           = 257,
  parameter int WIDTH          = 32,
  parameter int MAX_STEPS      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SIZE*WIDTH-1:0]          in_data,
  input  logic [2*MAX_STEPS-1:0]         cfg_seq,
  input  logic [$clog2(MAX_STEPS+1)-1:0] cfg_steps,
  output logic [1:0]                     perm_select,
  output logic [SIZE*WIDTH-1:0]          perm_in,
  input  logic [SIZE*WIDTH-1:0]          perm_out,
  output logic                           core_start,
  output logic [SIZE*WIDTH-1:0]          core_data,
  input  logic                           core_done,
  input  logic [SIZE*WIDTH-1:0]          core_result,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SIZE*WIDTH-1:0]          out_data,
  output logic                           busy,
  output logic [$clog2(MAX_STEPS)-1:0]   step_idx,
  output logic                           timeout_err
);

  localparam int VW = SIZE * WIDTH;
  localparam int SW = $clog2(MAX_STEPS + 1);
  localparam int IW = $clog2(MAX_STEPS);
  localparam int CW = (TIMEOUT_CYCLES > 1) ?
                      $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [SW-1:0] STEPS_MAX = SW'(MAX_STEPS);
  localparam logic [CW-1:0] WD_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    NO_PERM   = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    PERM,
    CORE_REQ,
    CORE_WAIT,
    OUT
  } state_e;

  state_e                 state_q, state_d;
  logic [VW-1:0]          buf_q, buf_d;
  logic [2*MAX_STEPS-1:0] seq_q, seq_d;
  logic [SW-1:0]          steps_q, steps_d;
  logic [IW-1:0]          step_q, step_d;
  logic [CW-1:0]          wd_q, wd_d;
  logic                   terr_q, terr_d;
  logic [1:0]             psel_q, psel_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   core_start_q, core_start_d;
  logic                   busy_q, busy_d;

  logic [SW-1:0]          steps_in;
  logic [IW-1:0]          step_nxt;
  logic                   last_step;

  assign steps_in  = (cfg_steps > STEPS_MAX) ? STEPS_MAX
                                             : cfg_steps;
  assign step_nxt  = step_q + IW'(1);
  // step_q < MAX_STEPS, so step_q+1 always fits in SW bits.
  assign last_step = (SW'(step_q) + SW'(1)) == steps_q;

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    seq_d        = seq_q;
    steps_d      = steps_q;
    step_d       = step_q;
    wd_d         = wd_q;
    terr_d       = terr_q;
    psel_d       = psel_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    core_start_d = 1'b0;
    busy_d       = busy_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_d      = in_data;
          seq_d      = cfg_seq;
          steps_d    = steps_in;
          step_d     = '0;
          terr_d     = 1'b0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          if (steps_in == '0) begin
            state_d     = OUT;
            out_valid_d = 1'b1;
          end else begin
            state_d = PERM;
            psel_d  = cfg_seq[1:0];
          end
        end
      end

      PERM: begin
        if (psel_q != NO_PERM) begin
          buf_d = perm_out;
        end
        core_start_d = 1'b1;
        state_d      = CORE_REQ;
      end

      CORE_REQ: begin
        wd_d    = '0;
        state_d = CORE_WAIT;
      end

      CORE_WAIT: begin
        if (core_done) begin
          buf_d = core_result;
          if (last_step) begin
            state_d     = OUT;
            out_valid_d = 1'b1;
          end else begin
            step_d  = step_nxt;
            // Select must be valid during the PERM cycle itself.
            psel_d  = seq_q[{step_nxt, 1'b0} +: 2];
            state_d = PERM;
          end
        end else if (wd_q == WD_LAST) begin
          // Abort: the vector is dropped, never presented.
          terr_d     = 1'b1;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end else begin
          wd_d = wd_q + CW'(1);
        end
      end

      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      buf_q        <= '0;
      seq_q        <= '0;
      steps_q      <= '0;
      step_q       <= '0;
      wd_q         <= '0;
      terr_q       <= 1'b0;
      psel_q       <= 2'd0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      seq_q        <= seq_d;
      steps_q      <= steps_d;
      step_q       <= step_d;
      wd_q         <= wd_d;
      terr_q       <= terr_d;
      psel_q       <= psel_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign core_start  = core_start_q;
  assign busy        = busy_q;
  assign perm_select = psel_q;
  assign step_idx    = step_q;
  assign timeout_err = terr_q;
  assign perm_in     = buf_q;
  assign core_data   = buf_q;
  assign out_data    = buf_q;

endmodule

// File: tb/tb_ntt_perm_sequencer.sv
// Bench for ntt_perm_sequencer: models the permutation network and the
// NTT core, and compares every result with a step-by-step reference.
module tb_ntt_perm_sequencer;

  localparam int SZ = 257;
  localparam int WD = 32;
  localparam int VW = SZ * WD;

  typedef logic [VW-1:0] vec_t;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  vec_t        in_data;
  logic [15:0] cfg_seq;
  logic [3:0]  cfg_steps;
  logic [1:0]  perm_select;
  vec_t        perm_in;
  vec_t        perm_out;
  logic        core_start;
  vec_t        core_data;
  logic        core_done;
  vec_t        core_result;
  logic        out_valid;
  logic        out_ready;
  vec_t        out_data;
  logic        busy;
  logic [2:0]  step_idx;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  // Core model state
  int          core_lat;
  logic [31:0] core_add;
  bit          core_en;
  bit          pend;
  int          cnt;
  vec_t        cap;
  int          n_start;

  ntt_perm_sequencer #(
    .SIZE(SZ), .WIDTH(WD), .MAX_STEPS(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_seq(cfg_seq), .cfg_steps(cfg_steps),
    .perm_select(perm_select), .perm_in(perm_in), .perm_out(perm_out),
    .core_start(core_start), .core_data(core_data),
    .core_done(core_done), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .step_idx(step_idx), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  // Source index of output element i under each permutation code.
  function automatic int p_src(input logic [1:0] code, input int i);
    int s;
    case (code)
      2'd0: begin
        if (i == 0) s = 256;
        else if (i == 256) s = 0;
        else s = (i % 16) * 16 + (i / 16);
      end
      2'd1: s = (3 * i) % SZ;
      2'd2: s = (i + 5) % SZ;
      default: s = i;
    endcase
    return s;
  endfunction

  function automatic vec_t permute(input logic [1:0] code, input vec_t v);
    vec_t r;
    r = '0;
    for (int i = 0; i < SZ; i++)
      r[i*WD +: WD] = v[p_src(code, i)*WD +: WD];
    return r;
  endfunction

  function automatic vec_t addv(input vec_t v, input logic [31:0] a);
    vec_t r;
    r = '0;
    for (int i = 0; i < SZ; i++)
      r[i*WD +: WD] = v[i*WD +: WD] + a;
    return r;
  endfunction

  function automatic logic [31:0] el(input vec_t v, input int i);
    return v[i*WD +: WD];
  endfunction

  function automatic vec_t rand_vec();
    vec_t r;
    r = '0;
    for (int i = 0; i < SZ; i++)
      r[i*WD +: WD] = $urandom;
    return r;
  endfunction

  assign perm_out = permute(perm_select, perm_in);

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input vec_t obs, input vec_t exp);
    int k;
    k = 0;
    for (int i = SZ - 1; i >= 0; i--)
      if (obs[i*WD +: WD] !== exp[i*WD +: WD]) k = i;
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: elem %0d got %0h want %0h", tag, k,
             obs[k*WD +: WD], exp[k*WD +: WD]);
    end
  endtask

  // One clock; inputs and the core model change only at negedge.
  task automatic tick();
    @(negedge clk);
    core_done = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        core_done   = 1'b1;
        core_result = addv(cap, core_add);
        pend        = 1'b0;
      end
    end
    if (core_start) begin
      n_start++;
      cap  = core_data;
      cnt  = core_lat;
      pend = core_en;
    end
  endtask

  task automatic run_vec(input vec_t v, input logic [15:0] seq,
                         input logic [3:0] steps, input int lat,
                         input logic [31:0] add, input int hold,
                         output vec_t res);
    int   n, c, k;
    bit   got;
    vec_t exp;
    n = (steps > 4'd8) ? 8 : int'(steps);
    exp = v;
    for (int s = 0; s < n; s++) begin
      if (seq[2*s +: 2] != 2'd3) exp = permute(seq[2*s +: 2], exp);
      exp = addv(exp, add);
    end
    res = exp;
    core_lat = lat;
    core_add = add;
    core_en  = 1'b1;
    n_start  = 0;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    in_data   = v;
    cfg_seq   = seq;
    cfg_steps = steps;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'd1);
    chk("terr_cleared", 64'(timeout_err), 64'd0);
    c = 0;
    k = 0;
    got = 1'b0;
    while (!got && c < 200) begin
      if (out_valid) begin
        got = 1'b1;
      end else begin
        if (core_start) begin
          chk("step_idx", 64'(step_idx), 64'(k));
          chk("perm_select", 64'(perm_select), 64'(seq[2*k +: 2]));
          k++;
        end
        tick();
        c++;
      end
    end
    chk("out_valid_seen", 64'(got), 64'd1);
    chk("latency", 64'(c), 64'(n * (lat + 2)));
    chk("core_starts", 64'(n_start), 64'(n));
    chkv("out_data", out_data, exp);
    chk("in_ready_in_out", 64'(in_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chkv("hold_data", out_data, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_drop", 64'(out_valid), 64'd0);
    chk("in_ready_back", 64'(in_ready), 64'd1);
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  vec_t        v;
  vec_t        res;
  logic [15:0] rseq;
  logic [3:0]  rsteps;
  int          w;

  initial begin
    rstn        = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    cfg_seq     = '0;
    cfg_steps   = '0;
    core_done   = 1'b0;
    core_result = '0;
    out_ready   = 1'b0;
    core_lat    = 1;
    core_add    = '0;
    core_en     = 1'b1;
    pend        = 1'b0;
    cnt         = 0;
    cap         = '0;
    n_start     = 0;
    tick();
    tick();
    rstn = 1'b1;
    tick();

    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_core_start", 64'(core_start), 64'd0);
    chk("rst_perm_select", 64'(perm_select), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_terr", 64'(timeout_err), 64'd0);
    chk("rst_step_idx", 64'(step_idx), 64'd0);
    chkv("rst_out_data", out_data, '0);

    // Zero steps: pass-through, one cycle.
    v = rand_vec();
    run_vec(v, 16'hffff, 4'd0, 1, 32'd0, 0, res);
    chk("zero_perm_select", 64'(perm_select), 64'd0);
    chkv("zero_passthru", res, v);

    // One step, permutation 0, identity core.
    v = rand_vec();
    run_vec(v, 16'h0000, 4'd1, 1, 32'd0, 0, res);
    chk("p0_el0", 64'(el(out_data, 0)), 64'(el(v, 256)));
    chk("p0_el1", 64'(el(out_data, 1)), 64'(el(v, 16)));
    chk("p0_el256", 64'(el(out_data, 256)), 64'(el(v, 0)));

    // Three steps {1,2,3}, core adds 1 after 5 cycles.
    v = rand_vec();
    run_vec(v, 16'h0039, 4'd3, 5, 32'd1, 0, res);

    // Output stall for 10 cycles.
    v = rand_vec();
    run_vec(v, 16'h0012, 4'd2, 2, 32'd7, 10, res);

    // Watchdog: core never answers.
    v = rand_vec();
    core_en   = 1'b0;
    in_data   = v;
    cfg_seq   = 16'h0000;
    cfg_steps = 4'd1;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 17; i++) begin
      chk("to_no_valid", 64'(out_valid), 64'd0);
      tick();
    end
    chk("to_busy_before", 64'(busy), 64'd1);
    chk("to_terr_before", 64'(timeout_err), 64'd0);
    tick();
    chk("to_terr", 64'(timeout_err), 64'd1);
    chk("to_idle", 64'(busy), 64'd0);
    chk("to_in_ready", 64'(in_ready), 64'd1);
    chk("to_out_valid", 64'(out_valid), 64'd0);
    tick();
    chk("to_sticky", 64'(timeout_err), 64'd1);
    core_en = 1'b1;

    // Next vector clears the error (checked inside run_vec).
    v = rand_vec();
    run_vec(v, 16'h0002, 4'd1, 3, 32'd5, 0, res);

    // Random vectors, including a clamped step count.
    for (int r = 0; r < 7; r++) begin
      v      = rand_vec();
      rseq   = 16'($urandom);
      rsteps = (r == 6) ? 4'd12 : 4'($urandom_range(0, 8));
      run_vec(v, rseq, rsteps, $urandom_range(1, 4), $urandom, 0, res);
    end

    // Reset during CORE_WAIT with core_done high in that cycle.
    v = rand_vec();
    core_lat  = 3;
    in_data   = v;
    cfg_seq   = 16'h0005;
    cfg_steps = 4'd2;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    w = 0;
    while (!core_done && w < 40) begin
      tick();
      w++;
    end
    chk("rstw_done_seen", 64'(core_done), 64'd1);
    chk("rstw_busy", 64'(busy), 64'd1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("rstw_busy0", 64'(busy), 64'd0);
    chk("rstw_in_ready", 64'(in_ready), 64'd1);
    chk("rstw_out_valid", 64'(out_valid), 64'd0);
    chk("rstw_step_idx", 64'(step_idx), 64'd0);
    chk("rstw_perm_select", 64'(perm_select), 64'd0);
    chkv("rstw_buf", out_data, '0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstw_no_valid", 64'(out_valid), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
